// File: rtl/des_round_sequencer_if.sv
// Handshake bundle between the DES round sequencer, its block source/sink,
// and the external round function (expansion, S-boxes, P-permutation).
interface des_round_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_decrypt;
    logic        f_req;
    logic [31:0] f_r;
    logic [3:0]  f_key_idx;
    logic        f_ack;
    logic [31:0] f_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  round;
    logic        busy;

    // Environment side: block source, round function and result sink.
    modport master (
        output in_valid, in_data, in_decrypt, f_ack, f_result, out_ready,
        input  in_ready, f_req, f_r, f_key_idx, out_valid, out_data, round, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, in_decrypt, f_ack, f_result, out_ready,
        output in_ready, f_req, f_r, f_key_idx, out_valid, out_data, round, busy
    );
endinterface

// File: rtl/des_round_sequencer.sv
// Sixteen-round DES Feistel sequencer: holds L/R, requests one round-function
// evaluation per round, and presents the pre-final-permutation block {R16,L16}.
module des_round_sequencer (
    input  logic                  clk,
    input  logic                  rst,
    des_round_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] l_half;
    logic [31:0] r_half;
    logic        mode;
    logic [3:0]  round_q;
    logic [3:0]  key_idx_q;
    logic        in_ready_q;
    logic        f_req_q;
    logic        out_valid_q;
    logic        busy_q;

    // NOTE: every state and output register uses <= so all of them see the
    // pre-edge values of l_half/r_half; the Feistel swap relies on this.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            l_half      <= '0;
            r_half      <= '0;
            mode        <= 1'b0;
            round_q     <= 4'd0;
            key_idx_q   <= 4'd0;
            in_ready_q  <= 1'b1;
            f_req_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        l_half      <= bus.in_data[63:32];
                        r_half      <= bus.in_data[31:0];
                        mode        <= bus.in_decrypt;
                        round_q     <= 4'd0;
                        key_idx_q   <= bus.in_decrypt ? 4'd15 : 4'd0;
                        state       <= ROUND;
                        in_ready_q  <= 1'b0;
                        f_req_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ROUND: begin
                    if (bus.f_ack) begin
                        l_half <= r_half;
                        r_half <= l_half ^ bus.f_result;
                        if (round_q == 4'd15) begin
                            state       <= DONE;
                            f_req_q     <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            round_q   <= round_q + 4'd1;
                            // Decryption walks the key schedule backwards.
                            key_idx_q <= mode ? key_idx_q - 4'd1 : key_idx_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    // in_ready rises only after this edge, so a block offered
                    // during the output handshake waits one more cycle.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    f_req_q     <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.f_req     = f_req_q;
    assign bus.f_r       = r_half;
    assign bus.f_key_idx = key_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = {r_half, l_half};
    assign bus.round     = round_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer: stubbed round function with
// programmable ack latency, latency/data/key-order checks, stalls and reset.
`timescale 1ns/1ps
module tb_des_round_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_round_sequencer_if bus ();

    des_round_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Round-function stub: stub_delay=0 acks every cycle, otherwise acks
    // after stub_delay wait cycles of each request.
    logic        ack_en;
    int unsigned stub_delay;
    logic [1:0]  f_mode;
    int unsigned wait_cnt = 0;

    always @(posedge clk) begin
        if (!bus.f_req || bus.f_ack) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    assign bus.f_ack = ack_en && ((stub_delay == 0) || (bus.f_req && wait_cnt == stub_delay));
    assign bus.f_result = (f_mode == 2'd0) ? 32'h0 :
                          (f_mode == 2'd1) ? bus.f_r :
                          (f_mode == 2'd2) ? ({bus.f_r[27:0], bus.f_r[31:28]} ^ {8{bus.f_key_idx}}) :
                                             32'hDEADBEEF;

    // Monitor: logs the key index of each accepted round and checks that
    // f_r/f_key_idx hold while a request waits.
    logic [63:0] key_seq;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_r;
    logic [3:0]  prev_k;

    always begin
        @(negedge clk);
        #2;
        if (bus.f_req && bus.f_ack) key_seq = {key_seq[59:0], bus.f_key_idx};
        if (hold_prev && bus.f_req && !rst) begin
            check("f_r_stable", {32'h0, bus.f_r}, {32'h0, prev_r});
            check("f_key_idx_stable", {60'h0, bus.f_key_idx}, {60'h0, prev_k});
        end
        hold_prev = bus.f_req && !bus.f_ack && !rst;
        prev_r    = bus.f_r;
        prev_k    = bus.f_key_idx;
    end

    // Offers one block, then counts cycles (capture edge = 0) until out_valid.
    task automatic run_block(input logic [63:0] data, input logic dec,
                             output int cyc, output logic [63:0] res);
        // NOTE: stimulus is driven with blocking assignments at the falling
        // edge so the DUT sees settled inputs at the next rising edge.
        bus.in_valid   = 1'b1;
        bus.in_data    = data;
        bus.in_decrypt = dec;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        res = bus.out_data;
    endtask

    task automatic finish_block();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc;
        int          n;
        logic [63:0] res;
        logic [63:0] enc;

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_decrypt = 1'b0;
        bus.out_ready  = 1'b0;
        ack_en         = 1'b0;
        stub_delay     = 0;
        f_mode         = 2'd0;
        key_seq        = '0;
        repeat (2) @(negedge clk);

        check("rst_in_ready",  {63'h0, bus.in_ready},  64'h1);
        check("rst_f_req",     {63'h0, bus.f_req},     64'h0);
        check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        check("rst_busy",      {63'h0, bus.busy},      64'h0);
        check("rst_round",     {60'h0, bus.round},     64'h0);
        check("rst_f_r",       {32'h0, bus.f_r},       64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Zero round function, ack every cycle: 16 swaps restore L/R.
        ack_en  = 1'b1;
        key_seq = '0;
        run_block(64'h0123456789ABCDEF, 1'b0, cyc, res);
        check("enc0_latency", 64'(cyc), 64'd17);
        check("enc0_data", res, 64'h89ABCDEF01234567);
        check("enc0_key_seq", key_seq, 64'h0123456789ABCDEF);
        check("done_round", {60'h0, bus.round}, 64'd15);
        check("done_busy", {63'h0, bus.busy}, 64'h1);
        check("done_in_ready", {63'h0, bus.in_ready}, 64'h0);
        finish_block();
        check("idle_in_ready", {63'h0, bus.in_ready}, 64'h1);
        check("idle_busy", {63'h0, bus.busy}, 64'h0);

        // Key-dependent round function: encrypt, then decrypt the result.
        f_mode  = 2'd2;
        key_seq = '0;
        run_block(64'h0123456789ABCDEF, 1'b0, cyc, enc);
        check("enc1_latency", 64'(cyc), 64'd17);
        check("enc1_key_seq", key_seq, 64'h0123456789ABCDEF);
        finish_block();
        key_seq = '0;
        run_block(enc, 1'b1, cyc, res);
        check("dec1_latency", 64'(cyc), 64'd17);
        check("dec1_key_seq", key_seq, 64'hFEDCBA9876543210);
        check("dec1_roundtrip", res, 64'h0123456789ABCDEF);
        finish_block();

        // f_result = f_r, two wait cycles per round: L/R cycle with period 3.
        f_mode     = 2'd1;
        stub_delay = 2;
        run_block(64'h0123456789ABCDEF, 1'b0, cyc, res);
        check("wait_latency", 64'(cyc), 64'd49);
        check("wait_data", res, 64'h8888888889ABCDEF);

        // Output stall with ignored input offers.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 64'hFFFF0000FFFF0000;
            @(negedge clk);
            check("stall_out_valid", {63'h0, bus.out_valid}, 64'h1);
            check("stall_out_data", bus.out_data, 64'h8888888889ABCDEF);
            check("stall_in_ready", {63'h0, bus.in_ready}, 64'h0);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("hs_no_capture_busy", {63'h0, bus.busy}, 64'h0);
        check("hs_in_ready_next", {63'h0, bus.in_ready}, 64'h1);
        check("hs_out_valid", {63'h0, bus.out_valid}, 64'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("held_block_captured", {63'h0, bus.busy}, 64'h1);

        // Reset in the middle of round 7 with an ack pending.
        n = 0;
        while (bus.round != 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_round7", {60'h0, bus.round}, 64'd7);
        stub_delay = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", {63'h0, bus.busy}, 64'h0);
        check("mid_rst_round", {60'h0, bus.round}, 64'h0);
        check("mid_rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        check("mid_rst_f_req", {63'h0, bus.f_req}, 64'h0);
        check("mid_rst_f_r", {32'h0, bus.f_r}, 64'h0);
        f_mode = 2'd0;
        run_block(64'hFEDCBA9876543210, 1'b0, cyc, res);
        check("post_rst_latency", 64'(cyc), 64'd17);
        check("post_rst_data", res, 64'h76543210FEDCBA98);
        finish_block();

        // Stray f_ack/f_result in IDLE.
        f_mode = 2'd3;
        ack_en = 1'b0;
        @(negedge clk);
        ack_en = 1'b1;
        @(negedge clk);
        ack_en = 1'b0;
        check("idle_ack_busy", {63'h0, bus.busy}, 64'h0);
        check("idle_ack_round", {60'h0, bus.round}, 64'd15);
        check("idle_ack_f_r", {32'h0, bus.f_r}, 64'h76543210);
        check("idle_ack_in_ready", {63'h0, bus.in_ready}, 64'h1);

        // Stray f_ack/f_result in DONE.
        f_mode = 2'd0;
        ack_en = 1'b1;
        run_block(64'h0123456789ABCDEF, 1'b0, cyc, res);
        check("pre_done_data", res, 64'h89ABCDEF01234567);
        f_mode = 2'd3;
        repeat (2) @(negedge clk);
        check("done_ack_data", bus.out_data, 64'h89ABCDEF01234567);
        check("done_ack_round", {60'h0, bus.round}, 64'd15);
        check("done_ack_out_valid", {63'h0, bus.out_valid}, 64'h1);
        finish_block();
        check("final_idle", {63'h0, bus.in_ready}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
